fpmul_seq_ctrl: RTL and testbench
=================================

FPMUL_SEQ_CTRL -- requirements
Module: fpmul_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32: maximum cycles in WAIT before abort.
REQ-002 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid / in_ready  in / out  1 each  operand handshake.
REQ-005 SHALL have port op_a, op_b  in  32 each  IEEE-754 single operands.
REQ-006 SHALL have port out_valid / out_ready  out / in  1 each  result handshake.
REQ-007 SHALL have port result  out  32  packed product.
REQ-008 SHALL have port flags  out  4  {invalid, overflow, underflow, inexact}.
REQ-009 SHALL have port timeout_err  out  1  result aborted by watchdog.
REQ-010 SHALL have port mul_start  out  1  one-cycle start pulse to the 24x24 mantissa multiplier.
REQ-011 SHALL have port mul_plier, mul_plicand  out  24 each  significands with hidden bit.
REQ-012 SHALL have port mul_product  in  48; mul_done  in  1  multiplier result and done pulse.

Function
REQ-013 SHALL use states IDLE, CHECK, START, WAIT, NORM, ROUND, OUT; in_ready = (state==IDLE).
REQ-014 IDLE: on in_valid, register op_a/op_b -> CHECK.
REQ-015 CHECK: classify; special case (NaN, inf, zero, denormal) -> OUT with special result; else -> START.
REQ-016 Specials: any NaN or inf*0 -> 0x7FC00000; invalid set for sNaN input or inf*0; inf*finite -> signed inf; zero or denormal operand (flushed) -> signed zero, flags 0.
REQ-017 START: mul_start=1 exactly one cycle; mul_plier={1,frac_a}, mul_plicand={1,frac_b}, held stable from START until leaving WAIT -> WAIT.
REQ-018 WAIT: capture mul_product on cycle mul_done=1 -> NORM; mul_done outside WAIT ignored.
REQ-019 WAIT: watchdog counts cycles; at TIMEOUT without mul_done -> OUT with result 0x7FC00000, flags 0, timeout_err=1.
REQ-020 Sign = sa XOR sb; exponent 10-bit signed = ea+eb-127.
REQ-021 NORM: product[47]=1 -> mant=product[46:24], guard=product[23], sticky=|product[22:0], exp+1; else mant=product[45:23], guard=product[22], sticky=|product[21:0].
REQ-022 ROUND: round-to-nearest-even, increment when guard & (sticky | mant[0]); mantissa carry-out -> mant=0, exp+1; inexact = guard|sticky.
REQ-023 exp>=255 after round -> signed inf, overflow+inexact; exp<=0 -> signed zero, underflow+inexact (no denormal outputs).
REQ-024 OUT: out_valid=1, result/flags/timeout_err stable until out_ready; handshake -> IDLE.
REQ-025 Latency accept->out_valid: specials 2 cycles; normal = 4 + cycles from mul_start to mul_done.

Reset
REQ-026 Reset low SHALL asynchronously force state=IDLE, watchdog=0, mul_start=0, out_valid=0, result=0, flags=0, timeout_err=0, mul_plier=mul_plicand=0.
REQ-027 Reset mid-operation SHALL discard the operation; a late mul_done after reset SHALL be ignored.

Structure
REQ-028 Package fpmul_pkg SHALL hold state enum, BIAS=127, QNAN=32'h7FC00000, field width constants.
REQ-029 Sub-module fp_classify (combinational, per operand: is_zero, is_inf, is_nan, is_snan, is_denorm) SHALL be instantiated twice.

Verification
REQ-030 0x3FC00000 x 0x40000000 -> result 0x40400000, flags 0; one mul_start pulse, mul_plier=0xC00000, mul_plicand=0x800000.
REQ-031 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1; mul_start never asserted.
REQ-032 0x7F7FFFFF x 0x40000000 -> 0x7F800000, overflow+inexact.
REQ-033 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact only.
REQ-034 Model holds mul_done low -> after TIMEOUT WAIT cycles: out_valid, 0x7FC00000, timeout_err=1; next op completes normally.
REQ-035 Reset pulsed during WAIT -> all outputs at reset values; then out_ready held low 5 cycles on new op -> result stable, single transfer.

Source files
------------

// File: rtl/fpmul_seq_ctrl_pkg.sv
// fpmul_pkg: shared constants, state encoding and flag layout for the sequential FP multiplier controller
package fpmul_pkg;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int XEXP_W = 10;
  typedef enum logic [2:0] {IDLE, CHECK, START, WAIT, NORM, ROUND, OUT} state_t;
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;
endpackage

// File: rtl/fpmul_seq_ctrl_if.sv
// fpmul_seq_ctrl_if: operand and result handshakes of the FP multiplier controller
//   in_valid/in_ready/op_a/op_b : operand transfer (client -> controller)
//   out_valid/out_ready         : result transfer (controller -> client)
//   result/flags/timeout_err    : packed product, {invalid,overflow,underflow,inexact}, watchdog abort
interface fpmul_seq_ctrl_if;
  import fpmul_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic out_valid;
  logic out_ready;
  logic [31:0] result;
  logic [3:0] flags;
  logic timeout_err;
  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flags, timeout_err
  );
  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flags, timeout_err
  );
endinterface

// File: rtl/fpmul_seq_ctrl_fp_classify.sv
// fp_classify: combinational IEEE-754 single classification of one operand
//   x         : operand
//   is_zero   : +/-0
//   is_inf    : +/-inf
//   is_nan    : any NaN
//   is_snan   : signalling NaN (quiet bit clear)
//   is_denorm : subnormal
module fp_classify
  import fpmul_pkg::*;
(
  input  logic [31:0] x,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_snan,
  output logic        is_denorm
);
  logic exp_max, exp_min, frac_nz;
  assign exp_max = &x[30:FRAC_W];
  assign exp_min = ~|x[30:FRAC_W];
  assign frac_nz = |x[FRAC_W-1:0];
  assign is_zero = exp_min & ~frac_nz;
  assign is_denorm = exp_min & frac_nz;
  assign is_inf = exp_max & ~frac_nz;
  assign is_nan = exp_max & frac_nz;
  assign is_snan = is_nan & ~x[FRAC_W-1];
endmodule

// File: rtl/fpmul_seq_ctrl.sv
// fpmul_seq_ctrl: sequences one IEEE-754 single multiply through an external 24x24 mantissa multiplier
//   CLK, Reset               : rising-edge clock, asynchronous active-low reset
//   bus (slave)              : operand/result handshakes, result, flags, timeout_err
//   mul_start                : one-cycle start pulse to the mantissa multiplier
//   mul_plier, mul_plicand   : significands with hidden bit, held from START through WAIT
//   mul_product, mul_done    : multiplier product and its done pulse (only honoured in WAIT)
module fpmul_seq_ctrl
  import fpmul_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic                CLK,
  input  logic                Reset,
  fpmul_seq_ctrl_if.slave     bus,
  output logic                mul_start,
  output logic [SIG_W-1:0]    mul_plier,
  output logic [SIG_W-1:0]    mul_plicand,
  input  logic [PROD_W-1:0]   mul_product,
  input  logic                mul_done
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0] flags_q, flags_d;
  logic tmo_q, tmo_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [SIG_W-1:0] plier_q, plier_d, plicand_q, plicand_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic sign_q, sign_d;
  logic signed [XEXP_W-1:0] exp_q, exp_d;
  logic [FRAC_W-1:0] mant_q, mant_d;
  logic guard_q, guard_d, sticky_q, sticky_d;
  logic za, ia, na, sa, da, zb, ib, nb, sb, db;
  fp_classify u_cls_a (.x(a_q), .is_zero(za), .is_inf(ia), .is_nan(na), .is_snan(sa), .is_denorm(da));
  fp_classify u_cls_b (.x(b_q), .is_zero(zb), .is_inf(ib), .is_nan(nb), .is_snan(sb), .is_denorm(db));
  // Denormals are flushed, so they behave as zero everywhere, including inf*denorm.
  logic zero_a, zero_b, nan_out, inv, special, sgn;
  logic [31:0] spec_res;
  assign zero_a = za | da;
  assign zero_b = zb | db;
  assign sgn = a_q[31] ^ b_q[31];
  assign nan_out = na | nb | (ia & zero_b) | (ib & zero_a);
  assign inv = sa | sb | (ia & zero_b) | (ib & zero_a);
  assign special = nan_out | ia | ib | zero_a | zero_b;
  assign spec_res = nan_out ? QNAN : (ia | ib) ? {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} : {sgn, 31'd0};
  logic signed [XEXP_W-1:0] exp_sum;
  assign exp_sum = $signed({2'b00, a_q[30:FRAC_W]}) + $signed({2'b00, b_q[30:FRAC_W]}) - $signed(XEXP_W'(BIAS));
  logic inc, ovf, unf;
  logic [SIG_W-1:0] mant_r;
  logic signed [XEXP_W-1:0] exp_r;
  logic [31:0] round_res;
  assign inc = guard_q & (sticky_q | mant_q[0]);
  assign mant_r = {1'b0, mant_q} + SIG_W'(inc);
  // A carry out of the rounded mantissa leaves the fraction bits at zero and bumps the exponent.
  assign exp_r = exp_q + $signed({{(XEXP_W-1){1'b0}}, mant_r[SIG_W-1]});
  assign ovf = exp_r >= $signed(XEXP_W'(255));
  assign unf = exp_r <= $signed(XEXP_W'(0));
  assign round_res = ovf ? {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} : unf ? {sign_q, 31'd0} : {sign_q, exp_r[EXP_W-1:0], mant_r[FRAC_W-1:0]};
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    result_d = result_q;
    flags_d = flags_q;
    tmo_d = tmo_q;
    wd_d = wd_q;
    plier_d = plier_q;
    plicand_d = plicand_q;
    prod_d = prod_q;
    sign_d = sign_q;
    exp_d = exp_q;
    mant_d = mant_q;
    guard_d = guard_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d = bus.op_a;
        b_d = bus.op_b;
        state_d = CHECK;
      end
      CHECK: begin
        sign_d = sgn;
        exp_d = exp_sum;
        if (special) begin
          result_d = spec_res;
          flags_d = {inv, 3'b000};
          tmo_d = 1'b0;
          state_d = OUT;
        end else begin
          plier_d = {1'b1, a_q[FRAC_W-1:0]};
          plicand_d = {1'b1, b_q[FRAC_W-1:0]};
          state_d = START;
        end
      end
      START: begin
        wd_d = '0;
        state_d = WAIT;
      end
      WAIT: if (mul_done) begin
        prod_d = mul_product;
        state_d = NORM;
      end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
        result_d = QNAN;
        flags_d = 4'b0000;
        tmo_d = 1'b1;
        state_d = OUT;
      end else begin
        wd_d = wd_q + 1'b1;
      end
      NORM: begin
        mant_d = prod_q[PROD_W-1] ? prod_q[46:24] : prod_q[45:23];
        guard_d = prod_q[PROD_W-1] ? prod_q[23] : prod_q[22];
        sticky_d = prod_q[PROD_W-1] ? |prod_q[22:0] : |prod_q[21:0];
        exp_d = exp_q + $signed({{(XEXP_W-1){1'b0}}, prod_q[PROD_W-1]});
        state_d = ROUND;
      end
      ROUND: begin
        result_d = round_res;
        flags_d = {1'b0, ovf, unf & ~ovf, ovf | unf | guard_q | sticky_q};
        tmo_d = 1'b0;
        state_d = OUT;
      end
      OUT: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      flags_q <= '0;
      tmo_q <= 1'b0;
      wd_q <= '0;
      plier_q <= '0;
      plicand_q <= '0;
      prod_q <= '0;
      sign_q <= 1'b0;
      exp_q <= '0;
      mant_q <= '0;
      guard_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
      flags_q <= flags_d;
      tmo_q <= tmo_d;
      wd_q <= wd_d;
      plier_q <= plier_d;
      plicand_q <= plicand_d;
      prod_q <= prod_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      mant_q <= mant_d;
      guard_q <= guard_d;
      sticky_q <= sticky_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == OUT;
  assign bus.result = result_q;
  assign bus.flags = flags_q;
  assign bus.timeout_err = tmo_q;
  assign mul_start = state_q == START;
  assign mul_plier = plier_q;
  assign mul_plicand = plicand_q;
endmodule

// File: tb/tb_fpmul_seq_ctrl.sv
// tb_fpmul_seq_ctrl: directed and random checks of fpmul_seq_ctrl against an arithmetic reference model
module tb_fpmul_seq_ctrl;
  import fpmul_pkg::*;
  localparam int TMO = 8;
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  logic mul_start;
  logic [23:0] mul_plier, mul_plicand;
  logic [47:0] mul_product = '0;
  logic mul_done = 1'b0;
  fpmul_seq_ctrl_if bus();
  fpmul_seq_ctrl #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .Reset(Reset), .bus(bus),
    .mul_start(mul_start), .mul_plier(mul_plier), .mul_plicand(mul_plicand),
    .mul_product(mul_product), .mul_done(mul_done)
  );
  always #5 CLK = ~CLK;
  int n_chk = 0;
  int n_fail = 0;
  bit hang = 1'b0;
  int fix_delay = 0;
  int cd = 0;
  int starts = 0;
  logic [47:0] pend;
  logic [23:0] seen_pl, seen_pc;
  // Mantissa multiplier model: product returned after a random (or fixed) delay, or never when hung.
  always @(posedge CLK) begin
    mul_done <= 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mul_done <= 1'b1;
        mul_product <= pend;
      end
    end
    if (mul_start) begin
      starts++;
      seen_pl = mul_plier;
      seen_pc = mul_plicand;
      pend = 48'(mul_plier) * 48'(mul_plicand);
      cd = hang ? 0 : (fix_delay != 0 ? fix_delay : int'($urandom_range(1, 6)));
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, output logic [31:0] r, output logic [3:0] f);
    int ea, eb, e, sh;
    longint unsigned p, m, rem, half;
    bit nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zer_a, zer_b, s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    nan_a = ea == 255 && a[22:0] != 0;
    nan_b = eb == 255 && b[22:0] != 0;
    snan_a = nan_a && !a[22];
    snan_b = nan_b && !b[22];
    inf_a = ea == 255 && a[22:0] == 0;
    inf_b = eb == 255 && b[22:0] == 0;
    zer_a = ea == 0;
    zer_b = eb == 0;
    s = a[31] ^ b[31];
    if (nan_a || nan_b) begin
      r = QNAN;
      f = {snan_a | snan_b, 3'b000};
    end else if ((inf_a && zer_b) || (inf_b && zer_a)) begin
      r = QNAN;
      f = 4'b1000;
    end else if (inf_a || inf_b) begin
      r = {s, 8'hFF, 23'd0};
      f = 4'b0000;
    end else if (zer_a || zer_b) begin
      r = {s, 31'd0};
      f = 4'b0000;
    end else begin
      p = (longint'(a[22:0]) + (64'd1 << 23)) * (longint'(b[22:0]) + (64'd1 << 23));
      e = ea + eb - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e++;
      end
      m = p >> sh;
      rem = p - (m << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (m & 64'd1) != 0)) m++;
      if (m == (64'd1 << 24)) begin
        m = 64'd1 << 23;
        e++;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 4'b0011;
      end else begin
        r = {s, e[7:0], m[22:0]};
        f = {3'b000, rem != 0};
      end
    end
  endfunction
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int rdly,
                        output logic [31:0] r, output logic [3:0] f, output logic t,
                        output int lat, output bit stable, output bit gone);
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(negedge CLK);
      lat++;
    end
    r = bus.result;
    f = bus.flags;
    t = bus.timeout_err;
    stable = 1'b1;
    repeat (rdly) begin
      @(negedge CLK);
      if (bus.out_valid !== 1'b1 || bus.result !== r || bus.flags !== f || bus.timeout_err !== t) stable = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    gone = bus.out_valid === 1'b0;
  endtask
  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b, input int rdly, input bit tmo, output int lat);
    logic [31:0] er, r;
    logic [3:0] ef, f;
    logic t;
    bit stable, gone;
    if (tmo) begin
      er = QNAN;
      ef = 4'b0000;
    end else ref_mul(a, b, er, ef);
    run_op(a, b, rdly, r, f, t, lat, stable, gone);
    chk({tag, ".bound"}, 64'(lat < 200), 64'd1);
    chk({tag, ".result"}, 64'(r), 64'(er));
    chk({tag, ".flags"}, 64'(f), 64'(ef));
    chk({tag, ".tmo"}, 64'(t), 64'(tmo));
    chk({tag, ".stable"}, 64'(stable), 64'd1);
    chk({tag, ".single"}, 64'(gone), 64'd1);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".result"}, 64'(bus.result), 64'd0);
    chk({tag, ".flags"}, 64'(bus.flags), 64'd0);
    chk({tag, ".tmo"}, 64'(bus.timeout_err), 64'd0);
    chk({tag, ".mul_start"}, 64'(mul_start), 64'd0);
    chk({tag, ".plier"}, 64'(mul_plier), 64'd0);
    chk({tag, ".plicand"}, 64'(mul_plicand), 64'd0);
  endtask
  function automatic logic [31:0] rnd_op();
    logic [31:0] x;
    int k;
    x = $urandom;
    k = int'($urandom_range(0, 9));
    if (k == 0) x[30:23] = 8'h00;
    else if (k == 1) x[30:23] = 8'hFF;
    else if (k < 6) x[30:23] = 8'($urandom_range(100, 154));
    else if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) x[30:23] = 8'd127;
    return x;
  endfunction
  initial begin
    int lat, s0;
    bit idle_ok;
    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    Reset = 1'b1;
    s0 = starts;
    op_check("mul_1p5x2", 32'h3FC00000, 32'h40000000, 0, 1'b0, lat);
    chk("mul_1p5x2.starts", 64'(starts - s0), 64'd1);
    chk("mul_1p5x2.plier", 64'(seen_pl), 64'hC00000);
    chk("mul_1p5x2.plicand", 64'(seen_pc), 64'h800000);
    s0 = starts;
    op_check("inf_x_zero", 32'h7F800000, 32'h00000000, 0, 1'b0, lat);
    chk("inf_x_zero.starts", 64'(starts - s0), 64'd0);
    chk("inf_x_zero.latency", 64'(lat), 64'd2);
    op_check("overflow", 32'h7F7FFFFF, 32'h40000000, 1, 1'b0, lat);
    op_check("inexact", 32'h3F800001, 32'h3F800001, 0, 1'b0, lat);
    op_check("snan", 32'h7F800001, 32'h3F800000, 0, 1'b0, lat);
    op_check("qnan", 32'hFFC00123, 32'h40000000, 0, 1'b0, lat);
    op_check("neg_inf", 32'hFF800000, 32'h40000000, 0, 1'b0, lat);
    op_check("denorm", 32'h80000001, 32'h40400000, 0, 1'b0, lat);
    op_check("underflow", 32'h00800000, 32'h00800000, 0, 1'b0, lat);
    op_check("round_carry", 32'h3FFFFFFF, 32'h3F800001, 0, 1'b0, lat);
    hang = 1'b1;
    op_check("timeout", 32'h40000000, 32'h40400000, 2, 1'b1, lat);
    chk("timeout.latency", 64'(lat), 64'(TMO + 3));
    hang = 1'b0;
    op_check("after_timeout", 32'h40000000, 32'h40400000, 0, 1'b0, lat);
    fix_delay = 6;
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.op_a = 32'h40000000;
    bus.op_b = 32'h40400000;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    @(negedge CLK);
    chk("rst_wait.start_pulse", 64'(mul_start), 64'd1);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    @(negedge CLK);
    Reset = 1'b1;
    idle_ok = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || mul_start !== 1'b0) idle_ok = 1'b0;
    end
    chk("rst_wait.late_done_ignored", 64'(idle_ok), 64'd1);
    fix_delay = 0;
    op_check("post_reset_hold", 32'hC0A00000, 32'h3E800000, 5, 1'b0, lat);
    for (int i = 0; i < 40; i++) op_check("random", rnd_op(), rnd_op(), int'($urandom_range(0, 2)), 1'b0, lat);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
